// File: rtl/usb_fs_in_transactor.sv
// ============================================================================
// Module   : usb_fs_in_transactor
// Purpose  : Answers full-speed IN tokens with DATAx+payload+CRC16, NAK or
//            STALL; holds the packet until the host ACKs it.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module usb_fs_in_transactor #(
    parameter int MAX_PKT = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_inToken,
    input  logic                       i_ackRcvd,
    input  logic                       i_timeout,
    input  logic                       i_resetToggle,
    input  logic                       i_etStall,
    output logic                       o_etReady,
    input  logic                       i_etValid,
    input  logic [8*MAX_PKT-1:0]       i_etData,
    input  logic [$clog2(MAX_PKT):0]   i_etData_nBytes,
    output logic                       o_txValid,
    input  logic                       i_txReady,
    output logic [7:0]                 o_txData,
    output logic                       o_txLast,
    output logic                       o_busy
);

    localparam int c_CW = $clog2(MAX_PKT) + 1;
    localparam int c_IW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

    localparam logic [7:0] c_PID_STALL = 8'h1E;
    localparam logic [7:0] c_PID_NAK   = 8'h5A;
    localparam logic [7:0] c_PID_DATA0 = 8'hC3;
    localparam logic [7:0] c_PID_DATA1 = 8'h4B;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HSK     = 3'd1,
        S_PID     = 3'd2,
        S_DATA    = 3'd3,
        S_CRCLO   = 3'd4,
        S_CRCHI   = 3'd5,
        S_WAITACK = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_toggle;
    logic              r_pending;
    logic              r_etReady;
    logic [7:0]        r_hsk;
    logic [7:0]        r_snap [MAX_PKT];
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   r_idx;
    logic [15:0]       r_crc;

    logic              w_txActive;
    logic              w_accept;
    logic              w_lastByte;
    logic [c_CW-1:0]   w_nSat;
    logic [7:0]        w_dataByte;

    // USB CRC16, reflected form: bits enter LSB-first
    function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_txActive = (r_state == S_HSK)   || (r_state == S_PID) ||
                        (r_state == S_DATA)  || (r_state == S_CRCLO) ||
                        (r_state == S_CRCHI);
    assign w_accept   = w_txActive && i_txReady;
    assign w_lastByte = (r_idx == (r_count - c_CW'(1)));
    assign w_nSat     = (i_etData_nBytes > c_CW'(MAX_PKT)) ? c_CW'(MAX_PKT) : i_etData_nBytes;
    assign w_dataByte = r_snap[r_idx[c_IW-1:0]];
    assign o_txValid  = w_txActive;
    assign o_etReady  = r_etReady;
    assign o_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_txData    = 8'h00;
        o_txLast    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_inToken) begin
                    if (i_etStall)                    w_state_nxt = S_HSK;
                    else if (r_pending || i_etValid)  w_state_nxt = S_PID;
                    else                              w_state_nxt = S_HSK;
                end
            end
            S_HSK: begin
                o_txData = r_hsk;
                o_txLast = 1'b1;
                if (i_txReady) w_state_nxt = S_IDLE;
            end
            S_PID: begin
                o_txData = r_toggle ? c_PID_DATA1 : c_PID_DATA0;
                if (i_txReady) w_state_nxt = (r_count == '0) ? S_CRCLO : S_DATA;
            end
            S_DATA: begin
                o_txData = w_dataByte;
                if (i_txReady && w_lastByte) w_state_nxt = S_CRCLO;
            end
            S_CRCLO: begin
                o_txData = ~r_crc[7:0];
                if (i_txReady) w_state_nxt = S_CRCHI;
            end
            S_CRCHI: begin
                o_txData = ~r_crc[15:8];
                o_txLast = 1'b1;
                if (i_txReady) w_state_nxt = S_WAITACK;
            end
            S_WAITACK: begin
                // ACK beats a coincident timeout; a fresh token implies a timeout
                if (i_ackRcvd)      w_state_nxt = S_IDLE;
                else if (i_timeout) w_state_nxt = S_IDLE;
                else if (i_inToken) w_state_nxt = S_PID;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_toggle  <= 1'b0;
            r_pending <= 1'b0;
            r_etReady <= 1'b0;
            r_hsk     <= 8'h00;
            r_count   <= '0;
            r_idx     <= '0;
            r_crc     <= 16'hFFFF;
            for (int b = 0; b < MAX_PKT; b++) r_snap[b] <= 8'h00;
        end else begin
            r_etReady <= 1'b0;

            if ((r_state == S_IDLE) && i_inToken) begin
                if (i_etStall) begin
                    r_hsk <= c_PID_STALL;
                end else if (r_pending || i_etValid) begin
                    // Snapshot only once; retransmits reuse the held copy
                    if (!r_pending) begin
                        for (int b = 0; b < MAX_PKT; b++) r_snap[b] <= i_etData[8*b +: 8];
                        r_count   <= w_nSat;
                        r_pending <= 1'b1;
                    end
                end else begin
                    r_hsk <= c_PID_NAK;
                end
            end

            if ((w_state_nxt == S_PID) && (r_state != S_PID)) begin
                r_crc <= 16'hFFFF;
                r_idx <= '0;
            end

            if ((r_state == S_DATA) && w_accept) begin
                r_crc <= f_crc16(r_crc, w_dataByte);
                r_idx <= r_idx + c_CW'(1);
            end

            if ((r_state == S_WAITACK) && i_ackRcvd) begin
                r_etReady <= 1'b1;
                r_toggle  <= ~r_toggle;
                r_pending <= 1'b0;
            end

            if (i_resetToggle) r_toggle <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_fs_in_transactor.sv
// ============================================================================
// Module   : tb_usb_fs_in_transactor
// Purpose  : Scoreboard bench for usb_fs_in_transactor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_usb_fs_in_transactor;

    localparam int MAX_PKT = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_token, ack, tmo, rst_tog, et_stall, et_valid;
    logic [63:0] et_data;
    logic [3:0]  et_n;
    logic        et_ready, tx_valid, tx_last, busy;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        rand_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int rdy_seen = 0;
    int rdy_exp = 0;

    logic [8:0] sb [$];   // {last, data}

    usb_fs_in_transactor #(.MAX_PKT(MAX_PKT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_inToken(in_token), .i_ackRcvd(ack),
        .i_timeout(tmo), .i_resetToggle(rst_tog), .i_etStall(et_stall),
        .o_etReady(et_ready), .i_etValid(et_valid), .i_etData(et_data),
        .i_etData_nBytes(et_n), .o_txValid(tx_valid), .i_txReady(tx_ready),
        .o_txData(tx_data), .o_txLast(tx_last), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every accepted byte, checks hold stability while stalled
    logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = 8'h00;
    always @(negedge clk) begin
        if (rstn) begin
            if (et_ready) rdy_seen++;
            if (p_valid && !p_ready)
                chk("tx_hold", {tx_valid, tx_last, tx_data}, {1'b1, p_last, p_data});
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    chk("tx_unexpected", {tx_last, tx_data}, 9'h1FF);
                end else begin
                    chk("tx_byte", {tx_last, tx_data}, sb.pop_front());
                end
            end
        end
        p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data; p_last = tx_last;
    end

    function automatic logic [15:0] crc_model(input logic [63:0] d, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (c[0] ^ d[8*k+i]) c = (c >> 1) ^ 16'hA001;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic exp_pkt(input logic [7:0] pid, input logic [63:0] d, input int n);
        logic [15:0] crc = crc_model(d, n);
        sb.push_back({1'b0, pid});
        for (int k = 0; k < n; k++) sb.push_back({1'b0, d[8*k +: 8]});
        sb.push_back({1'b0, crc[7:0]});
        sb.push_back({1'b1, crc[15:8]});
    endtask

    task automatic pulse_token();
        @(posedge clk); #1 in_token = 1'b1;
        @(posedge clk); #1 in_token = 1'b0;
        chk("tx_latency", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0: ack = 1'b1;
            1: tmo = 1'b1;
            2: rst_tog = 1'b1;
            default: begin ack = 1'b1; tmo = 1'b1; end
        endcase
        @(posedge clk); #1 ack = 1'b0; tmo = 1'b0; rst_tog = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
        if (sb.size() != 0) begin
            chk({name, "_drain_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic ack_and_check(input int which, input string name);
        pulse(which);
        rdy_exp++;
        repeat (2) @(posedge clk);
        chk(name, rdy_seen, rdy_exp);
        #1 chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_token = 0; ack = 0; tmo = 0; rst_tog = 0;
        et_stall = 0; et_valid = 0; et_data = '0; et_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {et_ready, tx_valid, tx_last, busy, tx_data}, 12'h000);
        rstn = 1'b1;

        // NAK when nothing is queued
        sb.push_back({1'b1, 8'h5A});
        pulse_token(); drain("nak");
        chk("nak_no_ready", rdy_seen, 0);

        // STALL wins over an available packet, which stays unconsumed
        et_valid = 1; et_data = 64'h33_22_11; et_n = 4'd3; et_stall = 1;
        sb.push_back({1'b1, 8'h1E});
        pulse_token(); drain("stall");
        chk("stall_no_ready", rdy_seen, 0);
        et_stall = 0;

        // 3-byte DATA0, ACK
        exp_pkt(8'hC3, 64'h33_22_11, 3);
        pulse_token(); drain("pkt3");
        ack_and_check(0, "pkt3_ready");

        // toggled to DATA1
        et_data = 64'h5A_A5; et_n = 4'd2;
        exp_pkt(8'h4B, 64'h5A_A5, 2);
        pulse_token(); drain("pkt2");
        ack_and_check(0, "pkt2_ready");

        // zero-length DATA0: CRC bytes are 0x00 0x00
        et_n = 4'd0;
        sb.push_back({1'b0, 8'hC3}); sb.push_back({1'b0, 8'h00}); sb.push_back({1'b1, 8'h00});
        pulse_token(); drain("zlp");
        ack_and_check(0, "zlp_ready");

        // toggle is DATA1 here; force back to DATA0, then timeout/retransmit
        pulse(2);
        et_data = 64'h33_22_11; et_n = 4'd3;
        exp_pkt(8'hC3, 64'h33_22_11, 3);
        pulse_token(); drain("retx_first");
        pulse(1);
        repeat (2) @(posedge clk);
        chk("timeout_no_ready", rdy_seen, rdy_exp);
        et_data = 64'h99_88_77_66_55; et_n = 4'd5;
        exp_pkt(8'hC3, 64'h33_22_11, 3);
        pulse_token(); drain("retx_second");
        ack_and_check(0, "retx_ready");

        // ACK outside WAITACK is ignored
        pulse(0);
        repeat (2) @(posedge clk);
        chk("stray_ack", rdy_seen, rdy_exp);

        // DATA1 under random back-pressure; ACK+timeout together counts as ACK
        rand_en = 1'b1;
        et_data = 64'h05_04_03_02_01; et_n = 4'd5;
        exp_pkt(8'h4B, 64'h05_04_03_02_01, 5);
        pulse_token(); drain("rand");
        rand_en = 1'b0;
        ack_and_check(3, "ack_tmo_ready");

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_fs_in_transactor.md
Name: usb_fs_in_transactor

Overview:
Downstream of the full-speed endpoint packet sender. Consumes its packet interface (et* handshake: ready/valid, packed data, byte count, stall) and answers host IN tokens. Answers with DATA0/DATA1 + payload + CRC16, NAK, or STALL, as a byte stream to the packet serializer. Tracks the data toggle, waits for the host ACK, and retransmits on timeout; the packet is released upstream only after ACK.

Parameters:
MAX_PKT, 8, maximum payload bytes per packet; must equal the upstream packer's MAX_PKT.

Ports:
i_clk  in  1  clock.
i_rstn  in  1  asynchronous active-low reset.
i_inToken  in  1  one-cycle pulse: IN token addressed to this endpoint decoded.
i_ackRcvd  in  1  one-cycle pulse: ACK handshake received from host.
i_timeout  in  1  one-cycle pulse: host response timeout expired.
i_resetToggle  in  1  one-cycle pulse: force data toggle to DATA0 (SETUP/SetConfiguration).
i_etStall  in  1  endpoint halted.
o_etReady  out  1  packet consumed (one-cycle pulse).
i_etValid  in  1  packet available.
i_etData  in  8*MAX_PKT  packed payload, byte b at bits [8b+7:8b].
i_etData_nBytes  in  $clog2(MAX_PKT)+1  payload byte count.
o_txValid  out  1  tx byte valid.
i_txReady  in  1  serializer accepts byte.
o_txData  out  8  tx byte.
o_txLast  out  1  current tx byte is last of packet.
o_busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; toggle=DATA0; pending=0; snapshot data/count=0; o_etReady, o_txValid, o_txLast, o_busy = 0; o_txData = 0x00.
- States: IDLE, HSK, PID, DATA, CRCLO, CRCHI, WAITACK.
- IDLE + i_inToken, priority order:
  - i_etStall → HSK with byte 0x1E (STALL).
  - Else if pending or i_etValid → PID. If !pending: snapshot i_etData and count (count saturated to MAX_PKT), set pending.
  - Else → HSK with byte 0x5A (NAK).
- Latency: o_txValid rises the cycle after the token.
- Tx handshake: o_txValid/o_txData/o_txLast held stable until i_txReady; advance only on o_txValid && i_txReady.
- HSK: single byte, o_txLast=1; on accept → IDLE. Pending and toggle unchanged.
- PID: byte 0xC3 if toggle=DATA0, 0x4B if DATA1. Next state DATA, or CRCLO if count=0.
- DATA: emit snapshot bytes 0..count-1 in order; byte index counter; after last accept → CRCLO.
- CRC16 (USB):
  - Computed over payload bytes only, LSB-first; reflected poly 0xA001, init 0xFFFF, updated on each DATA accept.
  - Transmitted value is the bitwise complement: CRCLO sends low byte, CRCHI sends high byte with o_txLast=1.
  - Zero-length packet → CRC bytes 0x00, 0x00.
- CRCHI accept → WAITACK.
- WAITACK:
  - i_ackRcvd: o_etReady=1 for exactly one cycle (next cycle), toggle flips, pending clears → IDLE.
  - i_timeout: → IDLE, pending and toggle kept; next IN token retransmits the identical snapshot with the same PID.
  - i_inToken: implicit timeout, → PID directly (retransmit).
  - ACK and timeout in the same cycle: ACK wins.
- i_ackRcvd/i_timeout outside WAITACK: ignored. i_inToken outside IDLE/WAITACK: ignored.
- i_resetToggle: toggle=DATA0 in any state, effective next cycle. Does not abort a packet in flight or clear pending.
- Upstream contract: while pending, i_etData/i_etData_nBytes are not sampled. o_etReady pulses only after ACK, while upstream holds i_etValid=1.
- Async reset mid-packet: immediate return to reset values; the in-flight packet is abandoned; upstream data is untouched (never released).

Test Plan:
- Token with i_etValid=0, i_etStall=0 → single byte 0x5A, o_txLast=1; no o_etReady.
- Token with i_etStall=1, i_etValid=1 → single byte 0x1E; packet not consumed.
- Packet nBytes=3 {0x11,0x22,0x33}, token, i_txReady=1 → 0xC3,0x11,0x22,0x33, CRC lo/hi matching the bench CRC16 model, last on CRC hi. Then ACK → o_etReady pulse 1 cycle; next packet starts with 0x4B.
- Zero-length (nBytes=0) packet → 0xC3, 0x00, 0x00.
- Same 3-byte packet sent, i_timeout, upstream count changed to 5 → retransmit identical 0xC3 packet with 3 bytes; then ACK → toggle DATA1.
- i_txReady toggled pseudo-randomly → no byte dropped or duplicated, o_txData stable while stalled. i_resetToggle while toggle=DATA1 → next PID 0xC3.
